// File: rtl/mic1_pkg.sv
// Shared constants and state encodings for the MIC-1 memory interface.
package mic1_pkg;

    // Default bus widths.
    localparam int unsigned MIC1_ADDR_W = 32;
    localparam int unsigned MIC1_DATA_W = 32;

    // Bit positions of the memory-control field inside the MIR.
    localparam int unsigned MIR_MEM_W = 3;
    localparam int unsigned MIR_WRITE = 2;
    localparam int unsigned MIR_READ  = 1;
    localparam int unsigned MIR_FETCH = 0;

    // Data-port controller states.
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_READ  = 2'd1,
        D_WRITE = 2'd2
    } d_state_t;

    // Fetch-port controller states.
    typedef enum logic {
        F_IDLE = 1'b0,
        F_BUSY = 1'b1
    } f_state_t;

endpackage

// File: rtl/mic1_req_channel.sv
// Generic req/ack holder: latches the address on start, keeps the request
// up until ack, captures read data and emits a one-cycle valid pulse.
module mic1_req_channel #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    logic              r_busy;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    // Transaction holder: start only when idle, finish on ack; acks while idle are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_rd     <= 1'b0;
            r_addr   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_busy <= 1'b1;
                    r_rd   <= i_rd;
                    r_addr <= i_addr;
                end
            end else if (i_ack) begin
                r_busy <= 1'b0;
                if (r_rd) begin
                    r_rdata  <= i_rdata;
                    r_rvalid <= 1'b1;
                end
            end
        end
    end

    assign o_req    = r_busy;
    assign o_addr   = r_addr;
    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

// File: rtl/mic1_mem_interface.sv
// MIC-1 memory-interface stage: independent byte fetch and word data ports,
// stalling the sequencer while a requested channel is still busy.
module mic1_mem_interface
    import mic1_pkg::*;
#(
    parameter int unsigned ADDR_W = MIC1_ADDR_W,
    parameter int unsigned DATA_W = MIC1_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr,
    input  logic              mem_rd,
    input  logic              mem_fetch,
    input  logic [ADDR_W-1:0] mar,
    input  logic [DATA_W-1:0] mdr_out,
    input  logic [ADDR_W-1:0] pc,
    output logic [7:0]        mbr,
    output logic              mbr_valid,
    output logic [DATA_W-1:0] mdr_in,
    output logic              mdr_load,
    output logic              stall,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              d_rd_req,
    output logic              d_wr_req,
    input  logic              d_ack,
    input  logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] i_addr,
    output logic              i_req,
    input  logic              i_ack,
    input  logic [7:0]        i_rdata
);

    logic [MIR_MEM_W-1:0] w_mir;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_fetch;
    logic                 w_stall;
    logic                 w_d_start_wr;
    logic                 w_d_start_rd;
    logic                 w_f_start;

    d_state_t             r_d_state;
    d_state_t             w_d_next;
    f_state_t             r_f_state;
    f_state_t             w_f_next;

    logic                 w_d_is_rd;
    logic                 w_d_is_wr;
    logic                 w_f_is_busy;

    logic                 w_d_req;
    logic [ADDR_W-1:0]    w_d_addr;
    logic [DATA_W-1:0]    w_d_rdata;
    logic                 w_d_rvalid;
    logic [DATA_W-1:0]    r_d_wdata;

    logic                 w_i_req;
    logic [ADDR_W-1:0]    w_i_addr;
    logic [7:0]           w_i_rdata;
    logic                 w_i_rvalid;

    // Pack the MIR memory bits so they are addressed by field index.
    always_comb begin
        w_mir            = '0;
        w_mir[MIR_WRITE] = mem_wr;
        w_mir[MIR_READ]  = mem_rd;
        w_mir[MIR_FETCH] = mem_fetch;
    end

    assign w_wr    = w_mir[MIR_WRITE];
    assign w_rd    = w_mir[MIR_READ];
    assign w_fetch = w_mir[MIR_FETCH];

    // Whole command is refused if any channel it touches is busy.
    always_comb begin
        w_stall      = ((w_rd | w_wr) & (r_d_state != D_IDLE))
                     | (w_fetch & (r_f_state != F_IDLE));
        w_d_start_wr = ~w_stall & w_wr;
        w_d_start_rd = ~w_stall & w_rd & ~w_wr;
        w_f_start    = ~w_stall & w_fetch;
    end

    // Data FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_state <= D_IDLE;
        end else begin
            r_d_state <= w_d_next;
        end
    end

    // Data FSM next state: write wins over a simultaneous read.
    always_comb begin
        w_d_next = r_d_state;
        case (r_d_state)
            D_IDLE: begin
                if (w_d_start_wr) begin
                    w_d_next = D_WRITE;
                end else if (w_d_start_rd) begin
                    w_d_next = D_READ;
                end
            end
            D_READ, D_WRITE: begin
                if (d_ack) begin
                    w_d_next = D_IDLE;
                end
            end
            default: w_d_next = D_IDLE;
        endcase
    end

    // Data FSM outputs: direction qualifiers for the shared request.
    always_comb begin
        w_d_is_rd = (r_d_state == D_READ);
        w_d_is_wr = (r_d_state == D_WRITE);
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_state <= F_IDLE;
        end else begin
            r_f_state <= w_f_next;
        end
    end

    // Fetch FSM next state.
    always_comb begin
        w_f_next = r_f_state;
        case (r_f_state)
            F_IDLE:  if (w_f_start) w_f_next = F_BUSY;
            F_BUSY:  if (i_ack)     w_f_next = F_IDLE;
            default: w_f_next = F_IDLE;
        endcase
    end

    // Fetch FSM outputs.
    always_comb begin
        w_f_is_busy = (r_f_state == F_BUSY);
    end

    // Write data is only captured by the write path; reads leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_wdata <= '0;
        end else if (w_d_start_wr) begin
            r_d_wdata <= mdr_out;
        end
    end

    mic1_req_channel #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_ch (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_d_start_wr | w_d_start_rd),
        .i_rd     (w_d_start_rd),
        .i_addr   (mar),
        .i_ack    (d_ack),
        .i_rdata  (d_rdata),
        .o_req    (w_d_req),
        .o_addr   (w_d_addr),
        .o_rdata  (w_d_rdata),
        .o_rvalid (w_d_rvalid)
    );

    mic1_req_channel #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_fetch_ch (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_f_start),
        .i_rd     (1'b1),
        .i_addr   (pc),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .o_req    (w_i_req),
        .o_addr   (w_i_addr),
        .o_rdata  (w_i_rdata),
        .o_rvalid (w_i_rvalid)
    );

    assign stall     = w_stall;
    assign d_addr    = w_d_addr;
    assign d_wdata   = r_d_wdata;
    assign d_rd_req  = w_d_req & w_d_is_rd;
    assign d_wr_req  = w_d_req & w_d_is_wr;
    assign mdr_in    = w_d_rdata;
    assign mdr_load  = w_d_rvalid;
    assign i_addr    = w_i_addr;
    assign i_req     = w_i_req & w_f_is_busy;
    assign mbr       = w_i_rdata;
    assign mbr_valid = w_i_rvalid;

endmodule

// File: tb/tb_mic1_mem_interface.sv
// Directed bench for mic1_mem_interface with a scoreboard for read results.
module tb_mic1_mem_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr, mem_rd, mem_fetch;
    logic [31:0] mar, mdr_out, pc;
    logic [7:0]  mbr;
    logic        mbr_valid;
    logic [31:0] mdr_in;
    logic        mdr_load, stall;
    logic [31:0] d_addr, d_wdata;
    logic        d_rd_req, d_wr_req, d_ack;
    logic [31:0] d_rdata;
    logic [31:0] i_addr;
    logic        i_req, i_ack;
    logic [7:0]  i_rdata;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    logic [7:0]  q_mbr[$];
    logic [31:0] q_mdr[$];

    always #5 clk = ~clk;

    mic1_mem_interface #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_fetch(mem_fetch),
        .mar(mar), .mdr_out(mdr_out), .pc(pc),
        .mbr(mbr), .mbr_valid(mbr_valid),
        .mdr_in(mdr_in), .mdr_load(mdr_load), .stall(stall),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .i_addr(i_addr), .i_req(i_req), .i_ack(i_ack), .i_rdata(i_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the next queued result.
    always @(negedge clk) begin
        if (mbr_valid === 1'b1) begin
            if (q_mbr.size() == 0) chk("mbr_unexpected_pulse", 32'(mbr_valid), 32'd0);
            else                   chk("sb_mbr", 32'(mbr), 32'(q_mbr.pop_front()));
        end
        if (mdr_load === 1'b1) begin
            if (q_mdr.size() == 0) chk("mdr_unexpected_load", 32'(mdr_load), 32'd0);
            else                   chk("sb_mdr", mdr_in, q_mdr.pop_front());
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mem_wr = 0; mem_rd = 0; mem_fetch = 0;
        mar = '0; mdr_out = '0; pc = '0; d_ack = 0; d_rdata = '0; i_ack = 0; i_rdata = '0;
        cyc(); cyc();
        chk("rst_mbr", 32'(mbr), 32'd0);
        chk("rst_mdr_in", mdr_in, 32'd0);
        chk("rst_reqs", {28'd0, d_rd_req, d_wr_req, i_req, stall}, 32'd0);
        chk("rst_pulses", {30'd0, mbr_valid, mdr_load}, 32'd0);
        rst = 1'b0;
        cyc();

        // Fetch, zero wait
        pc = 32'h10; mem_fetch = 1; q_mbr.push_back(8'hA7);
        chk("f0_stall", 32'(stall), 32'd0);
        cyc();
        mem_fetch = 0;
        chk("f0_req", 32'(i_req), 32'd1);
        chk("f0_addr", i_addr, 32'h10);
        i_ack = 1; i_rdata = 8'hA7;
        cyc();
        i_ack = 0;
        chk("f0_valid", 32'(mbr_valid), 32'd1);
        chk("f0_mbr", 32'(mbr), 32'hA7);
        chk("f0_req_low", 32'(i_req), 32'd0);
        cyc();
        chk("f0_valid_once", 32'(mbr_valid), 32'd0);
        chk("f0_mbr_hold", 32'(mbr), 32'hA7);

        // Read, 3 wait states, mem_rd held while busy
        mar = 32'h40; mem_rd = 1; q_mdr.push_back(32'hDEADBEEF);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("rd_req_c%0d", i), 32'(d_rd_req), 32'd1);
            chk($sformatf("rd_stall_c%0d", i), 32'(stall), 32'd1);
            chk($sformatf("rd_noload_c%0d", i), 32'(mdr_load), 32'd0);
            if (i == 4) begin
                mem_rd = 0; d_ack = 1; d_rdata = 32'hDEADBEEF;
            end
            cyc();
        end
        d_ack = 0;
        chk("rd_addr", d_addr, 32'h40);
        chk("rd_req_low", 32'(d_rd_req), 32'd0);
        chk("rd_load", 32'(mdr_load), 32'd1);
        chk("rd_mdr", mdr_in, 32'hDEADBEEF);
        cyc();
        chk("rd_load_once", 32'(mdr_load), 32'd0);

        // Write with read also set: single write, no load
        mar = 32'h8; mdr_out = 32'h12345678; mem_wr = 1; mem_rd = 1;
        cyc();
        mem_wr = 0; mem_rd = 0;
        chk("wr_req", 32'(d_wr_req), 32'd1);
        chk("wr_no_rd", 32'(d_rd_req), 32'd0);
        chk("wr_data", d_wdata, 32'h12345678);
        chk("wr_addr", d_addr, 32'h8);
        d_ack = 1; d_rdata = 32'hCAFEF00D;
        cyc();
        d_ack = 0;
        chk("wr_req_low", 32'(d_wr_req), 32'd0);
        chk("wr_noload", 32'(mdr_load), 32'd0);
        chk("wr_mdr_kept", mdr_in, 32'hDEADBEEF);
        cyc();

        // Concurrent fetch and read, acks on different cycles
        pc = 32'h20; mar = 32'h44; mem_fetch = 1; mem_rd = 1;
        q_mbr.push_back(8'h5C); q_mdr.push_back(32'h0BADF00D);
        cyc();
        mem_fetch = 0; mem_rd = 0;
        chk("cc_both_req", {30'd0, i_req, d_rd_req}, 32'd3);
        i_ack = 1; i_rdata = 8'h5C;
        cyc();
        i_ack = 0;
        chk("cc_mbr_valid", 32'(mbr_valid), 32'd1);
        chk("cc_rd_pending", {30'd0, d_rd_req, mdr_load}, 32'd2);
        d_ack = 1; d_rdata = 32'h0BADF00D;
        cyc();
        d_ack = 0;
        chk("cc_mdr_load", {30'd0, mdr_load, mbr_valid}, 32'd2);
        cyc();

        // Busy fetch blocks the idle data channel too
        pc = 32'h30; mem_fetch = 1; q_mbr.push_back(8'h3C);
        cyc();
        mem_wr = 1; mar = 32'h70; mdr_out = 32'h55AA55AA;
        chk("blk_stall", 32'(stall), 32'd1);
        cyc();
        chk("blk_no_wr", 32'(d_wr_req), 32'd0);
        mem_wr = 0; mem_fetch = 0;
        i_ack = 1; i_rdata = 8'h3C;
        cyc();
        i_ack = 0;
        cyc();

        // Spurious acks while idle
        d_ack = 1; i_ack = 1; d_rdata = 32'hFFFFFFFF; i_rdata = 8'hFF;
        cyc(); cyc();
        d_ack = 0; i_ack = 0;
        chk("sp_mbr", 32'(mbr), 32'h3C);
        chk("sp_mdr", mdr_in, 32'h0BADF00D);
        chk("sp_pulses", {30'd0, mbr_valid, mdr_load}, 32'd0);
        cyc();

        // Reset in the middle of a read, ack during reset
        mar = 32'h60; mem_rd = 1;
        cyc();
        mem_rd = 0;
        cyc();
        chk("rr_req_before", 32'(d_rd_req), 32'd1);
        rst = 1; d_ack = 1; d_rdata = 32'h11111111;
        cyc();
        rst = 0; d_ack = 0;
        chk("rr_req_low", 32'(d_rd_req), 32'd0);
        chk("rr_noload", 32'(mdr_load), 32'd0);
        chk("rr_mdr", mdr_in, 32'd0);
        chk("rr_mbr", 32'(mbr), 32'd0);
        chk("rr_wdata", d_wdata, 32'd0);
        chk("rr_addrs", d_addr | i_addr, 32'd0);
        cyc();
        chk("rr_idle", {29'd0, d_rd_req, d_wr_req, mdr_load}, 32'd0);
        chk("rr_stall_idle", 32'(stall), 32'd0);
        cyc();

        chk("sb_mbr_drained", q_mbr.size(), 32'd0);
        chk("sb_mdr_drained", q_mdr.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
